// File: rtl/self_draw_if.sv
// Command and pixel-stream bus between the player controller, self_draw and the VGA adapter.
// The master side issues commands and consumes pixels. The slave side is the sequencer.
interface self_draw_if;
   logic       self_enable;
   logic [1:0] op;
   logic [7:0] x;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;
   logic       plot;
   logic       done;

   modport master (
      output self_enable, op, x,
      input  vga_x, vga_y, colour, plot, done
   );

   modport slave (
      input  self_enable, op, x,
      output vga_x, vga_y, colour, plot, done
   );
endinterface

// File: rtl/self_draw.sv
// Player-ship pixel sequencer: turns each draw/erase/fire command into a row-major stream of
// single-pixel VGA writes, followed by a one-cycle done pulse.
module self_draw #(
   parameter int          SHIP_W      = 10,
   parameter int          SHIP_H      = 4,
   parameter int          SHIP_Y      = 110,
   parameter int          FIRE_W      = 2,
   parameter int          FIRE_H      = 20,
   parameter int          SCREEN_W    = 160,
   parameter logic [2:0]  SHIP_COLOUR = 3'b010,
   parameter logic [2:0]  FIRE_COLOUR = 3'b100
) (
   input  logic        clk,
   input  logic        reset_n,
   self_draw_if.slave  bus
);

   localparam int COL_W = $clog2(SHIP_W > FIRE_W ? SHIP_W : FIRE_W);
   localparam int ROW_W = $clog2(SHIP_H > FIRE_H ? SHIP_H : FIRE_H);

   typedef enum logic [1:0] {IDLE, SHIP, FIRE, DONE} state_t;
   typedef enum logic [1:0] {OP_DRAW, OP_ERASE, OP_FIRE, OP_NOP} op_t;

   state_t             state, state_nxt;
   op_t                op_r, op_nxt;
   logic [7:0]         x0, x0_nxt;
   logic [COL_W-1:0]   col, col_nxt;
   logic [ROW_W-1:0]   row, row_nxt;
   logic [8:0]         col_sum;

   // NOTE: sequential state uses non-blocking assignments so every register samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         op_r  <= OP_DRAW;
         x0    <= '0;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         op_r  <= op_nxt;
         x0    <= x0_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_nxt = state;
      op_nxt    = op_r;
      x0_nxt    = x0;
      col_nxt   = col;
      row_nxt   = row;
      case (state)
         IDLE: begin
            if (bus.self_enable) begin
               op_nxt    = op_t'(bus.op);
               x0_nxt    = bus.x;
               col_nxt   = '0;
               row_nxt   = '0;
               state_nxt = (op_t'(bus.op) == OP_NOP) ? DONE : SHIP;
            end
         end
         SHIP: begin
            if (col == COL_W'(SHIP_W - 1)) begin
               col_nxt = '0;
               if (row == ROW_W'(SHIP_H - 1)) begin
                  row_nxt   = '0;
                  state_nxt = (op_r == OP_DRAW) ? DONE : FIRE;
               end else begin
                  row_nxt = row + 1'b1;
               end
            end else begin
               col_nxt = col + 1'b1;
            end
         end
         FIRE: begin
            if (col == COL_W'(FIRE_W - 1)) begin
               col_nxt = '0;
               if (row == ROW_W'(FIRE_H - 1)) begin
                  row_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  row_nxt = row + 1'b1;
               end
            end else begin
               col_nxt = col + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pixel outputs; the column sum is kept 9 bits wide so off-screen pixels are detected,
   // not wrapped onto the left edge. Clipped pixels still take their cycle.
   always_comb begin
      col_sum     = '0;
      bus.vga_x   = '0;
      bus.vga_y   = '0;
      bus.colour  = '0;
      bus.plot    = 1'b0;
      bus.done    = (state == DONE);
      case (state)
         SHIP: begin
            col_sum    = {1'b0, x0} + 9'(col);
            bus.vga_x  = col_sum[7:0];
            bus.vga_y  = 7'(SHIP_Y) + 7'(row);
            bus.colour = (op_r == OP_ERASE) ? 3'b000 : SHIP_COLOUR;
            bus.plot   = (col_sum < 9'(SCREEN_W));
         end
         FIRE: begin
            col_sum    = {1'b0, x0} + 9'(SHIP_W / 2 - 1) + 9'(col);
            bus.vga_x  = col_sum[7:0];
            bus.vga_y  = 7'(SHIP_Y - 1) - 7'(row);
            bus.colour = (op_r == OP_ERASE) ? 3'b000 : FIRE_COLOUR;
            bus.plot   = (col_sum < 9'(SCREEN_W));
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_self_draw.sv
// Directed bench for self_draw: draw, fire, erase, clipping, no-op, input latching,
// back-to-back no-ops and mid-command reset, each pixel checked against a reference model.
module tb_self_draw;

   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   self_draw_if bus ();

   self_draw dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected pixel k of a command: 40 ship pixels then 40 fire pixels.
   function automatic void model(input logic [1:0] op, input logic [7:0] xs, input int k,
                                 output logic [7:0] ex, output logic [6:0] ey,
                                 output logic [2:0] ec, output logic ep);
      int s;
      if (k < 40) begin
         s  = int'(xs) + k % 10;
         ey = 7'(110 + k / 10);
         ec = (op == 2'b01) ? 3'b000 : 3'b010;
      end else begin
         s  = int'(xs) + 4 + (k - 40) % 2;
         ey = 7'(109 - (k - 40) / 2);
         ec = (op == 2'b01) ? 3'b000 : 3'b100;
      end
      ex = 8'(s);
      ep = (s < 160);
   endfunction

   // Called just after a negedge with the DUT idle. When change_at >= 0 the enable is held
   // high until pixel change_at, where op, x and enable are all disturbed.
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] xs, input string tag,
                          input int change_at);
      int         n;
      logic [7:0] ex;
      logic [6:0] ey;
      logic [2:0] ec;
      logic       ep;
      n = (op == 2'b00) ? 40 : (op == 2'b11) ? 0 : 80;
      bus.self_enable = 1'b1;
      bus.op          = op;
      bus.x           = xs;
      @(negedge clk);
      if (change_at < 0) bus.self_enable = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (k == change_at) begin
            bus.x           = 8'd90;
            bus.op          = 2'b01;
            bus.self_enable = 1'b0;
         end
         model(op, xs, k, ex, ey, ec, ep);
         chk($sformatf("%s k%0d plot", tag, k), bus.plot, ep);
         chk($sformatf("%s k%0d vga_x", tag, k), bus.vga_x, ex);
         chk($sformatf("%s k%0d vga_y", tag, k), bus.vga_y, ey);
         chk($sformatf("%s k%0d colour", tag, k), bus.colour, ec);
         chk($sformatf("%s k%0d done", tag, k), bus.done, 1'b0);
         @(negedge clk);
      end
      chk($sformatf("%s done pulse", tag), bus.done, 1'b1);
      chk($sformatf("%s done plot", tag), bus.plot, 1'b0);
      @(negedge clk);
      chk($sformatf("%s after done", tag), bus.done, 1'b0);
      chk($sformatf("%s after plot", tag), bus.plot, 1'b0);
   endtask

   initial begin
      logic [7:0] ex;
      logic [6:0] ey;
      logic [2:0] ec;
      logic       ep;

      reset_n         = 1'b0;
      bus.self_enable = 1'b0;
      bus.op          = 2'b00;
      bus.x           = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst plot", bus.plot, 1'b0);
      chk("rst done", bus.done, 1'b0);
      chk("rst vga_x", bus.vga_x, 8'd0);
      chk("rst vga_y", bus.vga_y, 7'd0);
      chk("rst colour", bus.colour, 3'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle done", bus.done, 1'b0);
      chk("idle plot", bus.plot, 1'b0);

      run_cmd(2'b00, 8'd82,  "draw82",  -1);
      run_cmd(2'b10, 8'd50,  "fire50",  -1);
      run_cmd(2'b01, 8'd50,  "erase50", -1);
      run_cmd(2'b00, 8'd155, "clip155", -1);
      run_cmd(2'b11, 8'd0,   "nop",     -1);
      run_cmd(2'b10, 8'd20,  "latch",   10);
      repeat (3) begin
         @(negedge clk);
         chk("latch idle plot", bus.plot, 1'b0);
         chk("latch idle done", bus.done, 1'b0);
      end

      // No-op with enable held high: done every other cycle.
      bus.op          = 2'b11;
      bus.self_enable = 1'b1;
      @(negedge clk); chk("nop_cont d0", bus.done, 1'b1);
      @(negedge clk); chk("nop_cont d1", bus.done, 1'b0);
      @(negedge clk); chk("nop_cont d2", bus.done, 1'b1);
      bus.self_enable = 1'b0;
      @(negedge clk); chk("nop_cont d3", bus.done, 1'b0);
      @(negedge clk); chk("nop_cont d4", bus.done, 1'b0);

      // Reset during pixel 25 of a draw.
      bus.op          = 2'b00;
      bus.x           = 8'd30;
      bus.self_enable = 1'b1;
      @(negedge clk);
      bus.self_enable = 1'b0;
      for (int k = 0; k <= 25; k++) begin
         model(2'b00, 8'd30, k, ex, ey, ec, ep);
         chk($sformatf("pre_rst k%0d plot", k), bus.plot, ep);
         chk($sformatf("pre_rst k%0d vga_x", k), bus.vga_x, ex);
         if (k < 25) @(negedge clk);
      end
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid_rst plot", bus.plot, 1'b0);
      chk("mid_rst done", bus.done, 1'b0);
      chk("mid_rst vga_x", bus.vga_x, 8'd0);
      chk("mid_rst vga_y", bus.vga_y, 7'd0);
      chk("mid_rst colour", bus.colour, 3'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (16) begin
         @(negedge clk);
         chk("post_rst plot", bus.plot, 1'b0);
         chk("post_rst done", bus.done, 1'b0);
      end
      run_cmd(2'b00, 8'd82, "after_rst", -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
